// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
// Shared CPU definitions used by fetch and decode: datapath width, opcode
// constants, instruction field positions, the IF/ID bus layout and the
// fetch FSM state encoding.
package fetch_stage_pkg;

  localparam int unsigned DATA_W = 16;

  // Instruction field positions
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 7;
  localparam int RS_LO  = 4;
  localparam int RT_HI  = 3;
  localparam int RT_LO  = 0;

  // Opcodes
  localparam logic [3:0] OPC_ADD  = 4'h0;
  localparam logic [3:0] OPC_SUB  = 4'h1;
  localparam logic [3:0] OPC_AND  = 4'h2;
  localparam logic [3:0] OPC_OR   = 4'h3;
  localparam logic [3:0] OPC_SLL  = 4'h4;
  localparam logic [3:0] OPC_SRL  = 4'h5;
  localparam logic [3:0] OPC_ADDI = 4'h6;
  localparam logic [3:0] OPC_LW   = 4'h7;
  localparam logic [3:0] OPC_SW   = 4'h8;
  localparam logic [3:0] OPC_BEQ  = 4'h9;
  localparam logic [3:0] OPC_HLT  = 4'hF;

  localparam logic [DATA_W-1:0] CPU_NOP_INSTR = 16'h0000;

  // IF/ID bus layout as seen by decode: {pc, instr, valid}
  localparam int IFID_W        = 2 * DATA_W + 1;
  localparam int IFID_VALID    = 0;
  localparam int IFID_INSTR_LO = 1;
  localparam int IFID_INSTR_HI = DATA_W;
  localparam int IFID_PC_LO    = DATA_W + 1;
  localparam int IFID_PC_HI    = 2 * DATA_W;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  function automatic logic [3:0] opcode_of(input logic [DATA_W-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if
// Instruction-memory bus between the fetch stage (master) and the IM (slave).
//   im_addr  : word address, driven by fetch
//   im_rd_en : read enable, driven by fetch
//   im_instr : read data, combinational from im_addr, driven by the IM
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic [DATA_W-1:0] im_addr;
  logic              im_rd_en;
  logic [DATA_W-1:0] im_instr;

  modport master (output im_addr, output im_rd_en, input  im_instr);
  modport slave  (input  im_addr, input  im_rd_en, output im_instr);

endinterface

// File: rtl/fetch_stage_pc_next_sel.sv
// pc_next_sel
// Combinational next-PC select. Priority: branch redirect > hold > increment.
//   pc        : current PC
//   br_en     : take br_target
//   br_target : redirect destination
//   hold      : keep current PC
//   pc_next   : PC for the next edge
//   pc_incr   : pc + PC_INCR (modulo 2^16), also used as the IF/ID link PC
module pc_next_sel
  import fetch_stage_pkg::*;
#(
  parameter logic [DATA_W-1:0] PC_INCR = 16'd1
) (
  input  logic [DATA_W-1:0] pc,
  input  logic              br_en,
  input  logic [DATA_W-1:0] br_target,
  input  logic              hold,
  output logic [DATA_W-1:0] pc_next,
  output logic [DATA_W-1:0] pc_incr
);

  // Natural 16-bit truncation gives the required wrap with no carry flag.
  assign pc_incr = pc + PC_INCR;

  always_comb begin
    pc_next = pc_incr;
    if (br_en) begin
      pc_next = br_target;
    end else if (hold) begin
      pc_next = pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage: owns the PC, addresses instruction memory, applies
// branch redirects and hazard stalls, and produces the IF/ID register.
// An HLT opcode stops fetching, lets the pipeline drain for DRAIN_CYCLES
// non-stalled cycles, then raises a sticky hlt.
//   clk, rst_n           : clock, asynchronous active-low reset
//   stall                : hazard hold, freezes PC and IF/ID
//   br_taken, br_target  : resolved-taken branch redirect
//   im_bus               : instruction-memory bus (master side)
//   pc                   : current PC
//   if_id_pc/instr/valid : IF/ID register to decode
//   hlt                  : CPU halted
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC     = 16'h0000,
  parameter logic [DATA_W-1:0] PC_INCR      = 16'd1,
  parameter logic [3:0]        HLT_OPC      = OPC_HLT,
  parameter logic [DATA_W-1:0] NOP_INSTR    = CPU_NOP_INSTR,
  parameter int unsigned       DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [DATA_W-1:0] br_target,
  fetch_stage_if.master     im_bus,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] if_id_pc,
  output logic [DATA_W-1:0] if_id_instr,
  output logic              if_id_valid,
  output logic              hlt
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  fetch_state_t      state_q;
  logic [CNT_W-1:0]  drain_cnt_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] pc_next;
  logic [DATA_W-1:0] pc_incr;
  logic              is_hlt;
  logic              br_en;
  logic              pc_hold;

  assign is_hlt = (opcode_of(im_bus.im_instr) == HLT_OPC);

  // Once halted, redirects are ignored; outside FETCH the PC never advances.
  // A fetched HLT also freezes the PC so it keeps pointing at the HLT.
  assign br_en   = br_taken && (state_q != ST_HALTED);
  assign pc_hold = stall || (state_q != ST_FETCH) || is_hlt;

  pc_next_sel #(
    .PC_INCR (PC_INCR)
  ) u_pc_next_sel (
    .pc        (pc_q),
    .br_en     (br_en),
    .br_target (br_target),
    .hold      (pc_hold),
    .pc_next   (pc_next),
    .pc_incr   (pc_incr)
  );

  assign pc              = pc_q;
  assign im_bus.im_addr  = pc_q;
  assign im_bus.im_rd_en = (state_q == ST_FETCH) && !stall && !br_taken;

  // ---- IF -> IF/ID boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      drain_cnt_q <= '0;
      pc_q        <= RESET_PC;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      hlt         <= 1'b0;
    end else begin
      pc_q <= pc_next;
      case (state_q)
        ST_FETCH: begin
          if (br_taken) begin
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end else if (!stall) begin
            if_id_pc    <= pc_incr;
            if_id_instr <= im_bus.im_instr;
            if_id_valid <= 1'b1;
            if (is_hlt) begin
              state_q     <= ST_DRAIN;
              drain_cnt_q <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (br_taken) begin
            // An older branch squashes the HLT; resume fetching at the target.
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            drain_cnt_q <= '0;
            state_q     <= ST_FETCH;
          end else if (!stall) begin
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            if (drain_cnt_q == CNT_LAST) begin
              state_q <= ST_HALTED;
              hlt     <= 1'b1;
            end else begin
              drain_cnt_q <= drain_cnt_q + 1'b1;
            end
          end
        end
        ST_HALTED: begin
          if_id_pc    <= '0;
          if_id_instr <= NOP_INSTR;
          if_id_valid <= 1'b0;
          hlt         <= 1'b1;
        end
        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic [15:0] pc;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_instr;
  logic        if_id_valid;
  logic        hlt;

  int total = 0;
  int bad   = 0;

  logic [15:0] imem [0:65535];

  fetch_stage_if im_bus ();
  assign im_bus.im_instr = imem[im_bus.im_addr];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .im_bus      (im_bus.master),
    .pc          (pc),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
    .hlt         (hlt)
  );

  // Reference model: what the stage should hold after each edge.
  logic [15:0] m_pc;
  logic [15:0] m_ii;
  logic [15:0] m_ipc;
  logic        m_iv;
  logic        m_halted;
  logic        m_drain;
  int          m_left;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_ii = 16'h0000; m_ipc = 16'h0000; m_iv = 1'b0;
    m_halted = 1'b0; m_drain = 1'b0; m_left = 0;
  endtask

  task automatic model_step(input logic s, input logic b, input logic [15:0] t,
                            input logic [15:0] fetched);
    if (m_halted) begin
      m_ii = 16'h0000; m_iv = 1'b0;
    end else if (b) begin
      m_pc = t; m_ii = 16'h0000; m_iv = 1'b0; m_drain = 1'b0;
    end else if (s) begin
      // everything holds
    end else if (m_drain) begin
      m_ii = 16'h0000; m_iv = 1'b0;
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_halted = 1'b1; m_drain = 1'b0;
      end
    end else begin
      m_ii  = fetched;
      m_ipc = m_pc + 16'd1;
      m_iv  = 1'b1;
      if (fetched[15:12] == 4'hF) begin
        m_drain = 1'b1; m_left = 4;
      end else begin
        m_pc = m_pc + 16'd1;
      end
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_pc",    pc,          16'h0000);
    chk("rst_ipc",   if_id_pc,    16'h0000);
    chk("rst_instr", if_id_instr, 16'h0000);
    chk("rst_valid", if_id_valid, 1'b0);
    chk("rst_hlt",   hlt,         1'b0);
  endtask

  // Reset asserted on the low phase, released 1ns after a rising edge so the
  // next edge the bench models is the first fetch.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
    #1;
    chk_reset_vals();
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic cyc(input logic s, input logic b, input logic [15:0] t);
    logic [15:0] fetched;
    @(negedge clk);
    stall = s; br_taken = b; br_target = t;
    #1;
    chk("im_addr",  im_bus.im_addr, m_pc);
    chk("im_rd_en", im_bus.im_rd_en, !m_halted && !m_drain && !s && !b);
    fetched = imem[m_pc];
    @(posedge clk);
    model_step(s, b, t, fetched);
    #1;
    chk("pc",       pc,          m_pc);
    chk("if_valid", if_id_valid, m_iv);
    chk("if_instr", if_id_instr, m_ii);
    chk("hlt",      hlt,         m_halted);
    if (m_iv) chk("if_pc", if_id_pc, m_ipc);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
    for (int i = 0; i < 65536; i++) imem[i] = 16'h1000;
    imem[0]        = 16'h1123;
    imem[1]        = 16'h2234;
    imem[9]        = 16'hF000;
    imem[16'h0040] = 16'h1111;
    imem[16'hFFFF] = 16'h1234;

    // Sequential fetch after reset
    do_reset();
    cyc(0, 0, 0);
    chk("seq0_instr", if_id_instr, 16'h1123);
    chk("seq0_pc",    if_id_pc,    16'h0001);
    chk("seq0_valid", if_id_valid, 1'b1);
    cyc(0, 0, 0);
    chk("seq1_instr", if_id_instr, 16'h2234);
    chk("seq1_pc",    if_id_pc,    16'h0002);
    chk("seq1_pcreg", pc,          16'h0002);

    // Branch redirect from pc 5
    repeat (3) cyc(0, 0, 0);
    chk("pc_is5", pc, 16'h0005);
    cyc(0, 1, 16'h0040);
    chk("br_pc",    pc,          16'h0040);
    chk("br_valid", if_id_valid, 1'b0);
    chk("br_instr", if_id_instr, 16'h0000);
    cyc(0, 0, 0);
    chk("br_fetch", if_id_instr, 16'h1111);

    // Stall 3 cycles at pc 7, then stall+branch
    cyc(0, 1, 16'h0007);
    cyc(0, 0, 0);
    repeat (3) cyc(1, 0, 0);
    chk("stall_pc",    pc,          16'h0008);
    chk("stall_instr", if_id_instr, 16'h1000);
    cyc(1, 1, 16'h0010);
    chk("stbr_pc",    pc,          16'h0010);
    chk("stbr_valid", if_id_valid, 1'b0);

    // HLT at pc 9, drains 4 cycles then halts; sticky
    cyc(0, 1, 16'h0009);
    cyc(0, 0, 0);
    chk("hlt_instr", if_id_instr, 16'hF000);
    chk("hlt_valid", if_id_valid, 1'b1);
    chk("hlt_pc",    pc,          16'h0009);
    repeat (3) cyc(0, 0, 0);
    chk("hlt_early", hlt, 1'b0);
    cyc(0, 0, 0);
    chk("hlt_set", hlt, 1'b1);
    cyc(1, 1, 16'h0033);
    cyc(0, 1, 16'h0044);
    chk("hlt_sticky", hlt, 1'b1);
    chk("hlt_pcfrz",  pc,  16'h0009);

    // Branch squashes HLT two cycles into drain
    do_reset();
    cyc(0, 1, 16'h0009);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 16'h0020);
    chk("sq_pc", pc, 16'h0020);
    repeat (5) cyc(0, 0, 0);
    chk("sq_hlt", hlt, 1'b0);

    // Stalls during drain delay hlt by the stalled count
    cyc(0, 1, 16'h0009);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("dst_early", hlt, 1'b0);
    cyc(0, 0, 0);
    chk("dst_set", hlt, 1'b1);

    // PC wrap
    do_reset();
    cyc(0, 1, 16'hFFFF);
    cyc(0, 0, 0);
    chk("wrap_pc",   pc,       16'h0000);
    chk("wrap_ipc",  if_id_pc, 16'h0000);
    chk("wrap_inst", if_id_instr, 16'h1234);

    // Asynchronous reset mid-drain
    cyc(0, 1, 16'h0009);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 0, 0);
    chk("post_rst_instr", if_id_instr, imem[0]);

    // Randomized phase against the model
    for (int i = 0; i < 65536; i++) begin
      imem[i] = 16'($urandom);
      if (imem[i][15:12] == 4'hF && $urandom_range(0, 3) != 0) imem[i][15:12] = 4'h3;
    end
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        do_reset();
      end
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
